// File: rtl/hazard_unit_ms.sv
// ID-stage hazard detector: load-use / branch-compare stalls, memory-wait freeze,
// branch-comparator forward selects and a saturating stall-cycle counter.
//
// state  | meaning
// RUN    | normal operation, hazards evaluated combinationally each cycle
// LSTALL | extra load-latency stall cycles, lcnt counts down
// FREEZE | data memory busy; ret_state remembers where to resume
module hazard_unit_ms #(
    parameter int REG_AW    = 5,
    parameter int LOAD_LAT  = 1,
    parameter bit BR_FWD_EN = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_branch,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_alusrc,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              mem_regwrite,
    input  logic              mem_memtoreg,
    input  logic              mem_memop,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              dmem_ready,
    input  logic              clr_cnt,
    output logic              stall,
    output logic              idflush,
    output logic              freeze,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef enum logic [1:0] {RUN, LSTALL, FREEZE} state_t;

    localparam logic [1:0] LCNT_INIT = 2'(LOAD_LAT - 1);

    state_t     state, state_next;
    state_t     ret_state, ret_next;
    state_t     eff_state;
    logic [1:0] lcnt, lcnt_next;

    logic       frz_cond, rt_used;
    logic       rs_ex, rt_ex, rs_mem, rt_mem, rs_wb, rt_wb;
    logic       load_use, br_ex, br_mem;
    logic       stall_c, idflush_c, freeze_c;
    logic [1:0] fwd_a_c, fwd_b_c;

    // Register 0 is hardwired, so it never matches.
    always_comb begin
        rs_ex  = (ex_rd  != '0) && (id_rs == ex_rd);
        rt_ex  = (ex_rd  != '0) && (id_rt == ex_rd);
        rs_mem = (mem_rd != '0) && (id_rs == mem_rd);
        rt_mem = (mem_rd != '0) && (id_rt == mem_rd);
        rs_wb  = (wb_rd  != '0) && (id_rs == wb_rd);
        rt_wb  = (wb_rd  != '0) && (id_rt == wb_rd);
    end

    assign rt_used  = id_branch | ~id_alusrc;
    assign frz_cond = mem_memop & ~dmem_ready;
    assign load_use = ex_memread & (rs_ex | (rt_used & rt_ex));
    assign br_ex    = id_branch & ex_regwrite & (rs_ex | rt_ex);
    assign br_mem   = id_branch & mem_regwrite & (rs_mem | rt_mem)
                      & (mem_memtoreg | ~BR_FWD_EN);
    assign eff_state = (state == FREEZE) ? ret_state : state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            ret_state <= RUN;
            lcnt      <= 2'd0;
        end else begin
            state     <= state_next;
            ret_state <= ret_next;
            lcnt      <= lcnt_next;
        end
    end

    always_comb begin
        state_next = state;
        ret_next   = ret_state;
        lcnt_next  = lcnt;
        stall_c    = 1'b0;
        idflush_c  = 1'b0;
        freeze_c   = 1'b0;
        fwd_a_c    = 2'b00;
        fwd_b_c    = 2'b00;
        if (frz_cond) begin
            freeze_c = 1'b1;
            stall_c  = 1'b1;
            if (state != FREEZE) begin
                state_next = FREEZE;
                ret_next   = state;
            end
        end else if (eff_state == LSTALL) begin
            stall_c    = 1'b1;
            idflush_c  = 1'b1;
            lcnt_next  = lcnt - 2'd1;
            state_next = (lcnt <= 2'd1) ? RUN : LSTALL;
        end else begin
            state_next = RUN;
            if (load_use) begin
                stall_c   = 1'b1;
                idflush_c = 1'b1;
                if (LOAD_LAT > 1) begin
                    state_next = LSTALL;
                    lcnt_next  = LCNT_INIT;
                end
            end else if (br_ex || br_mem) begin
                stall_c   = 1'b1;
                idflush_c = 1'b1;
            end else begin
                if (id_branch && BR_FWD_EN && mem_regwrite && !mem_memtoreg && rs_mem)
                    fwd_a_c = 2'b01;
                else if (id_branch && wb_regwrite && rs_wb)
                    fwd_a_c = 2'b10;
                if (id_branch && BR_FWD_EN && mem_regwrite && !mem_memtoreg && rt_mem)
                    fwd_b_c = 2'b01;
                else if (id_branch && wb_regwrite && rt_wb)
                    fwd_b_c = 2'b10;
            end
        end
    end

    // Outputs are forced low while reset is held, even mid-cycle.
    always_comb begin
        stall   = stall_c   & rst_n;
        idflush = idflush_c & rst_n;
        freeze  = freeze_c  & rst_n;
        fwd_a   = rst_n ? fwd_a_c : 2'b00;
        fwd_b   = rst_n ? fwd_b_c : 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (clr_cnt)
            stall_cycles <= '0;
        else if (stall && (stall_cycles != {CNT_W{1'b1}}))
            stall_cycles <= stall_cycles + 1'b1;
    end

endmodule

// File: tb/tb_hazard_unit_ms.sv
// Randomized and directed checks of three hazard_unit_ms configurations against
// a cycle-level reference model that tracks remaining stall cycles as an integer.
module tb_hazard_unit_ms;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_branch, id_alusrc;
    logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
    logic       ex_regwrite, ex_memread;
    logic       mem_regwrite, mem_memtoreg, mem_memop;
    logic       wb_regwrite, dmem_ready, clr_cnt;

    logic       st [3];
    logic       idf[3];
    logic       fz [3];
    logic [1:0] fa [3];
    logic [1:0] fb [3];
    logic [3:0]  sc0;
    logic [15:0] sc1, sc2;

    int n_cmp = 0;
    int n_bad = 0;

    int rem[3];
    int cnt[3];

    typedef struct packed {
        logic       stall;
        logic       idflush;
        logic       freeze;
        logic [1:0] fa;
        logic [1:0] fb;
    } exp_t;

    always #5 clk = ~clk;

    // instance 0: LOAD_LAT=1, forwarding, 4-bit counter
    hazard_unit_ms #(.REG_AW(5), .LOAD_LAT(1), .BR_FWD_EN(1'b1), .CNT_W(4)) u0 (
        .clk(clk), .rst_n(rst_n), .id_branch(id_branch), .id_rs(id_rs), .id_rt(id_rt),
        .id_alusrc(id_alusrc), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_rd(ex_rd), .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg),
        .mem_memop(mem_memop), .mem_rd(mem_rd), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .dmem_ready(dmem_ready), .clr_cnt(clr_cnt), .stall(st[0]), .idflush(idf[0]),
        .freeze(fz[0]), .fwd_a(fa[0]), .fwd_b(fb[0]), .stall_cycles(sc0));

    // instance 1: LOAD_LAT=3, forwarding
    hazard_unit_ms #(.REG_AW(5), .LOAD_LAT(3), .BR_FWD_EN(1'b1), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .id_branch(id_branch), .id_rs(id_rs), .id_rt(id_rt),
        .id_alusrc(id_alusrc), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_rd(ex_rd), .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg),
        .mem_memop(mem_memop), .mem_rd(mem_rd), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .dmem_ready(dmem_ready), .clr_cnt(clr_cnt), .stall(st[1]), .idflush(idf[1]),
        .freeze(fz[1]), .fwd_a(fa[1]), .fwd_b(fb[1]), .stall_cycles(sc1));

    // instance 2: LOAD_LAT=2, no branch forwarding
    hazard_unit_ms #(.REG_AW(5), .LOAD_LAT(2), .BR_FWD_EN(1'b0), .CNT_W(16)) u2 (
        .clk(clk), .rst_n(rst_n), .id_branch(id_branch), .id_rs(id_rs), .id_rt(id_rt),
        .id_alusrc(id_alusrc), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_rd(ex_rd), .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg),
        .mem_memop(mem_memop), .mem_rd(mem_rd), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .dmem_ready(dmem_ready), .clr_cnt(clr_cnt), .stall(st[2]), .idflush(idf[2]),
        .freeze(fz[2]), .fwd_a(fa[2]), .fwd_b(fb[2]), .stall_cycles(sc2));

    function automatic int get_ll(int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : 2;
    endfunction

    function automatic bit get_bf(int k);
        return (k != 2);
    endfunction

    function automatic int get_max(int k);
        return (k == 0) ? 15 : 65535;
    endfunction

    function automatic int get_sc(int k);
        return (k == 0) ? int'(sc0) : (k == 1) ? int'(sc1) : int'(sc2);
    endfunction

    function automatic bit hit(logic [4:0] src, logic [4:0] dst);
        return (dst != 5'd0) && (src == dst);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    // Expected outputs for instance k this cycle and the remaining extra stall cycles after it.
    task automatic model_eval(input int k, output exp_t e, output int rem_n);
        bit rt_used, lu, bex, bmem, bf;
        e     = '0;
        rem_n = rem[k];
        bf    = get_bf(k);
        rt_used = id_branch || !id_alusrc;
        lu   = ex_memread && (hit(id_rs, ex_rd) || (rt_used && hit(id_rt, ex_rd)));
        bex  = id_branch && ex_regwrite && (hit(id_rs, ex_rd) || hit(id_rt, ex_rd));
        bmem = id_branch && mem_regwrite && (hit(id_rs, mem_rd) || hit(id_rt, mem_rd))
               && (mem_memtoreg || !bf);
        if (!rst_n) begin
            rem_n = 0;
        end else if (mem_memop && !dmem_ready) begin
            e.stall  = 1'b1;
            e.freeze = 1'b1;
        end else if (rem[k] > 0) begin
            e.stall   = 1'b1;
            e.idflush = 1'b1;
            rem_n     = rem[k] - 1;
        end else if (lu) begin
            e.stall   = 1'b1;
            e.idflush = 1'b1;
            rem_n     = get_ll(k) - 1;
        end else if (bex || bmem) begin
            e.stall   = 1'b1;
            e.idflush = 1'b1;
        end else begin
            if (id_branch && bf && mem_regwrite && !mem_memtoreg && hit(id_rs, mem_rd))
                e.fa = 2'b01;
            else if (id_branch && wb_regwrite && hit(id_rs, wb_rd))
                e.fa = 2'b10;
            if (id_branch && bf && mem_regwrite && !mem_memtoreg && hit(id_rt, mem_rd))
                e.fb = 2'b01;
            else if (id_branch && wb_regwrite && hit(id_rt, wb_rd))
                e.fb = 2'b10;
        end
    endtask

    task automatic step();
        exp_t e;
        int   rn;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            model_eval(k, e, rn);
            chk($sformatf("stall%0d", k),   32'(st[k]),  32'(e.stall));
            chk($sformatf("idflush%0d", k), 32'(idf[k]), 32'(e.idflush));
            chk($sformatf("freeze%0d", k),  32'(fz[k]),  32'(e.freeze));
            chk($sformatf("fwd_a%0d", k),   32'(fa[k]),  32'(e.fa));
            chk($sformatf("fwd_b%0d", k),   32'(fb[k]),  32'(e.fb));
            chk($sformatf("cnt%0d", k),     32'(get_sc(k)), 32'(cnt[k]));
            rem[k] = rn;
            if (!rst_n || clr_cnt)
                cnt[k] = 0;
            else if (e.stall && cnt[k] < get_max(k))
                cnt[k] = cnt[k] + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_branch = 0; id_alusrc = 0; id_rs = 0; id_rt = 0;
        ex_regwrite = 0; ex_memread = 0; ex_rd = 0;
        mem_regwrite = 0; mem_memtoreg = 0; mem_memop = 0; mem_rd = 0;
        wb_regwrite = 0; wb_rd = 0; dmem_ready = 1; clr_cnt = 0;
    endtask

    task automatic load_use8();
        idle();
        ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd8; id_rs = 5'd8;
    endtask

    task automatic randomize_inputs();
        id_branch    = 1'($urandom_range(0, 1));
        id_alusrc    = 1'($urandom_range(0, 1));
        id_rs        = 5'($urandom_range(0, 3));
        id_rt        = 5'($urandom_range(0, 3));
        ex_regwrite  = 1'($urandom_range(0, 1));
        ex_memread   = ($urandom_range(0, 3) == 0);
        ex_rd        = 5'($urandom_range(0, 3));
        mem_regwrite = 1'($urandom_range(0, 1));
        mem_memtoreg = ($urandom_range(0, 2) == 0);
        mem_memop    = ($urandom_range(0, 3) == 0);
        mem_rd       = 5'($urandom_range(0, 3));
        wb_regwrite  = 1'($urandom_range(0, 1));
        wb_rd        = 5'($urandom_range(0, 3));
        dmem_ready   = 1'($urandom_range(0, 1));
        clr_cnt      = ($urandom_range(0, 39) == 0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rem[k] = 0;
            cnt[k] = 0;
        end
        idle();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
        step();

        // single load-use: 1/3/2 stall cycles by instance
        clr_cnt = 1; step(); clr_cnt = 0;
        load_use8(); step();
        idle(); repeat (4) step();
        chk("ll1_cnt", 32'(sc0), 32'd1);
        chk("ll3_cnt", 32'(sc1), 32'd3);

        // r0 never hazards
        idle(); ex_memread = 1; ex_rd = 0; id_rs = 0; step();
        idle(); step();

        // independent branch forwards
        idle();
        id_branch = 1; mem_regwrite = 1; mem_rd = 5'd5; id_rs = 5'd5;
        wb_regwrite = 1; wb_rd = 5'd6; id_rt = 5'd6;
        step();
        idle(); step();

        // freeze while LOAD_LAT=3 instance sits in LSTALL with two cycles to go
        clr_cnt = 1; step(); clr_cnt = 0;
        load_use8(); step();
        idle(); mem_memop = 1; dmem_ready = 0; step(); step();
        idle(); step(); step();
        chk("frz_cnt", 32'(sc1), 32'd5);
        idle(); repeat (3) step();

        // saturation of the 4-bit counter, then clear during a stall
        clr_cnt = 1; step();
        load_use8(); repeat (20) step();
        chk("sat_cnt", 32'(sc0), 32'd15);
        clr_cnt = 1; step();
        chk("clr_cnt", 32'(sc0), 32'd0);
        idle(); repeat (4) step();

        // asynchronous reset while in LSTALL
        load_use8(); step();
        idle();
        #3 rst_n = 0;
        #1;
        chk("rst_stall", 32'(st[1]), 32'd0);
        chk("rst_idflush", 32'(idf[1]), 32'd0);
        chk("rst_freeze", 32'(fz[1]), 32'd0);
        chk("rst_cnt", 32'(sc1), 32'd0);
        for (int k = 0; k < 3; k++) begin
            rem[k] = 0;
            cnt[k] = 0;
        end
        step();
        rst_n = 1;
        step();

        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_unit_ms.md
Name: hazard_unit_ms

Overview:
- Parametrised successor to the ID-stage hazard detector of the 5-stage MIPS pipeline.
- Detects load-use and branch-compare hazards and holds stalls for a configurable load latency.
- Freezes the whole pipeline while data memory is not ready.
- Drives independent ID-stage branch-comparator forward selects for both operands from MEM and WB, and counts stall cycles for performance measurement.

Parameters:
REG_AW, 5, register-address width
LOAD_LAT, 1, cycles load data is unavailable after the load leaves EX (legal 1..4)
BR_FWD_EN, 1, 1 = forward MEM/WB ALU results to the branch comparator; 0 = stall on any MEM match instead
CNT_W, 16, stall-counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_branch  in  1  beq or bne in ID
id_rs  in  REG_AW  ID source rs
id_rt  in  REG_AW  ID source rt
id_alusrc  in  1  1 = rt not read (immediate) unless id_branch
ex_regwrite  in  1  EX instruction writes a register
ex_memread  in  1  EX instruction is a load
ex_rd  in  REG_AW  EX destination
mem_regwrite  in  1  MEM instruction writes a register
mem_memtoreg  in  1  MEM instruction is a load
mem_memop  in  1  MEM instruction accesses data memory
mem_rd  in  REG_AW  MEM destination
wb_regwrite  in  1  WB writes a register
wb_rd  in  REG_AW  WB destination
dmem_ready  in  1  data memory completes this cycle
clr_cnt  in  1  synchronous clear of stall_cycles
stall  out  1  hold PC and IF/ID
idflush  out  1  insert bubble into ID/EX
freeze  out  1  hold all pipeline registers
fwd_a  out  2  rs select: 00 regfile, 01 MEM result, 10 WB result
fwd_b  out  2  rt select, same encoding
stall_cycles  out  CNT_W  saturating count of cycles with stall=1

Behaviour:
- Definitions:
  - A match requires a nonzero destination: rd != 0 and equality with a source. Register 0 never causes a hazard or a forward.
  - rt_used = id_branch | ~id_alusrc.
- State machine: RUN, LSTALL, FREEZE. Down-counter lcnt is 2 bits wide.
- Reset (rst_n low, asynchronous):
  - state=RUN, lcnt=0, stall_cycles=0.
  - stall, idflush, freeze=0; fwd_a, fwd_b=00.
- Priority per cycle is FREEZE, then LSTALL, then RUN checks.
- FREEZE condition: mem_memop & ~dmem_ready.
  - Outputs: freeze=1, stall=1, idflush=0, fwd_a/fwd_b=00.
  - Entered from any state. lcnt holds.
  - On dmem_ready=1, returns to the state held before the freeze, and that cycle's outputs follow that state.
- LSTALL:
  - Outputs: stall=1, idflush=1, fwd 00.
  - lcnt decrements each non-frozen cycle. At lcnt=1 the next state is RUN.
- RUN, combinational on current inputs:
  - load_use = ex_memread & (rs matches ex_rd | rt_used & rt matches ex_rd). Outputs stall=1, idflush=1.
    - If LOAD_LAT>1: next state is LSTALL with lcnt=LOAD_LAT-1.
  - br_ex = id_branch & ex_regwrite & (rs or rt matches ex_rd). Outputs stall=1, idflush=1 for that cycle only.
  - br_mem = id_branch & mem_regwrite & (rs or rt matches mem_rd) & (mem_memtoreg | ~BR_FWD_EN). Outputs stall=1, idflush=1.
  - Otherwise stall=0, idflush=0.
    - fwd_a=01 if id_branch & BR_FWD_EN & mem_regwrite & ~mem_memtoreg & rs matches mem_rd.
    - Else fwd_a=10 if id_branch & wb_regwrite & rs matches wb_rd.
    - Else fwd_a=00.
    - fwd_b uses the same rule on rt. fwd_a and fwd_b are independent, so both may be nonzero together.
  - Whenever stall=1 in RUN, fwd outputs are 00.
- stall_cycles:
  - Increments on each clk edge where stall=1 and clr_cnt=0. Saturates at all-ones.
  - clr_cnt=1 loads 0; clear wins over increment.
- Reset mid-LSTALL or mid-FREEZE returns to RUN with all outputs 0 immediately.

Test Plan:
- LOAD_LAT=1: ex_memread=1, ex_rd=8, id_rs=8 -> stall=1, idflush=1 for exactly 1 cycle; stall_cycles=1.
- LOAD_LAT=3: same load-use -> stall=1, idflush=1 for 3 consecutive cycles, then 0; ex_rd=0 with id_rs=0 -> no stall.
- Branch: id_branch=1, mem_regwrite=1, mem_memtoreg=0, mem_rd=5, id_rs=5, wb_regwrite=1, wb_rd=6, id_rt=6 -> stall=0, fwd_a=01, fwd_b=10. Same inputs with BR_FWD_EN=0 -> stall=1, idflush=1, fwd 00.
- LOAD_LAT=3, freeze during LSTALL: mem_memop=1, dmem_ready=0 for 2 cycles at lcnt=2 -> freeze=1, idflush=0 for 2 cycles. Then 2 more LSTALL cycles follow, and stall_cycles advances by 5 in total.
- Saturation/clear: CNT_W=4, 20 stalled cycles -> stall_cycles=15. clr_cnt pulse during a stall -> 0.
- Asynchronous reset asserted in LSTALL between clock edges -> all outputs 0 immediately; after release, state is RUN.
